apb_controller: RTL

- APB-side master FSM of the AHB2APB bridge, downstream of the AHB slave interface.
- Converts each qualified AHB transfer (valid, pipelined address, write data, slave select) into an APB SETUP/ACCESS sequence.
- Stalls the AHB master via Hreadyout until the APB slave completes.
- Returns read data on Hrdata.

---
 rtl/apb_controller_pkg.sv | 16 +
 rtl/apb_controller.sv | 112 +++++++++++
 2 files changed

// File: rtl/apb_controller_pkg.sv
// apb_controller_pkg: shared AHB2APB bridge types, default widths and slave address map.
package apb_controller_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NSLV   = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_WWAIT, ST_SETUP, ST_ACCESS} state_e;
  localparam logic [DEF_ADDR_W-1:0] SLV0_BASE = 32'h8000_0000;
  localparam logic [DEF_ADDR_W-1:0] SLV1_BASE = 32'h8400_0000;
  localparam logic [DEF_ADDR_W-1:0] SLV2_BASE = 32'h8800_0000;
  localparam logic [DEF_ADDR_W-1:0] SLV_SIZE  = 32'h0400_0000;
  function automatic logic [DEF_NSLV-1:0] slv_decode(input logic [DEF_ADDR_W-1:0] addr);
    return {addr >= SLV2_BASE && addr < SLV2_BASE + SLV_SIZE,
            addr >= SLV1_BASE && addr < SLV1_BASE + SLV_SIZE,
            addr >= SLV0_BASE && addr < SLV0_BASE + SLV_SIZE};
  endfunction
endpackage

// File: rtl/apb_controller.sv
// apb_controller: APB master FSM turning qualified AHB transfers into SETUP/ACCESS sequences.
module apb_controller
  import apb_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NSLV   = DEF_NSLV
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic              Hwrite,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [NSLV-1:0]   tempselx,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic [DATA_W-1:0] Hrdata
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, paddr_q, paddr_d;
  logic [NSLV-1:0] sel_q, sel_d, psel_q, psel_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic penable_q, penable_d, pwrite_q, pwrite_d, hready_q, hready_d;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    pwdata_d  = pwdata_q;
    hrdata_d  = hrdata_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    hready_d  = hready_q;
    case (state_q)
      ST_IDLE: if (valid && |tempselx) begin
        hready_d = 1'b0;
        if (Hwrite) begin
          addr_d  = Haddr;
          sel_d   = tempselx;
          state_d = ST_WWAIT;
        end else begin
          paddr_d   = Haddr;
          psel_d    = tempselx;
          pwrite_d  = 1'b0;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      // Hwdata is stable here because Hreadyout is already low
      ST_WWAIT: begin
        paddr_d   = addr_q;
        psel_d    = sel_q;
        pwdata_d  = Hwdata;
        pwrite_d  = 1'b1;
        penable_d = 1'b0;
        state_d   = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: if (Pready) begin
        penable_d = 1'b0;
        psel_d    = '0;
        hready_d  = 1'b1;
        hrdata_d  = pwrite_q ? hrdata_q : Prdata;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      paddr_q   <= '0;
      psel_q    <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      hready_q  <= hready_d;
    end
  end
  assign Pselx     = psel_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hready_q;
  assign Hrdata    = hrdata_q;
endmodule
